ram_arbiter: RTL and testbench
==============================

Name: ram_arbiter

Overview:
- Arbitrates the single 2Kx8 static RAM (6116-class) between the MC14500 serial RAM path and a host loader/debug port.
- CPU side: the MAR/DOB shift registers and the FLAG_F/FLAG_O strobes.
- Host side: a req/ack handshake with full 11-bit addressing.
- The CPU cannot stall, so it has absolute, zero-latency priority. Host cycles run only in idle gaps; a preempted host cycle is aborted and retried.

Parameters:
- STROBE_CYCLES, 2, host WE/OE low-pulse width in clk cycles (1..15).
- RETRY_MAX, 15, saturation value of the host retry counter; reaching it asserts host_starve.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- cpu_addr  in  8  MAR contents; maps to RAM address {3'b000, cpu_addr}
- cpu_wdata  in  8  DOB contents
- cpu_rd  in  1  CPU read window (FLAG_F-derived), level
- cpu_wr  in  1  CPU write window (FLAG_O-derived), level
- cpu_rdata  out  8  RAM read data to DIA/DIB parallel load
- host_req  in  1  host request, level, held until host_ack
- host_we  in  1  1 = write, 0 = read; sampled with host_req
- host_addr  in  11  host RAM address
- host_wdata  in  8  host write data
- host_ack  out  1  one-cycle completion pulse
- host_rdata  out  8  registered read data, valid from host_ack onward
- host_starve  out  1  retry count at RETRY_MAX
- ram_addr  out  11  RAM address
- ram_wdata  out  8  RAM write data
- ram_data_oe  out  1  enable for the external data-bus driver
- ram_rdata  in  8  RAM data bus input
- ram_cs_b  out  1  chip select, active-low
- ram_we_b  out  1  write enable, active-low
- ram_oe_b  out  1  output enable, active-low

Behaviour:
- Reset, asynchronous: state IDLE, ram_cs_b = ram_we_b = ram_oe_b = 1, ram_data_oe = 0, ram_addr = 0, ram_wdata = 0, host_ack = 0, host_rdata = 0, retry_cnt = 0, host_starve = 0. While rst is high, all RAM controls are forced inactive, even if cpu_rd or cpu_wr is asserted.
- cpu_act = cpu_rd | cpu_wr.
- CPU override is combinational. In the same cycle cpu_act rises, the RAM outputs follow the CPU:
  - ram_addr = {3'b0, cpu_addr}, ram_cs_b = 0
  - ram_we_b = ~cpu_wr, ram_oe_b = ~(cpu_rd & ~cpu_wr)
  - ram_data_oe = cpu_wr, ram_wdata = cpu_wdata
  - This holds in every state.
- cpu_rd and cpu_wr both high: the write wins and OE stays high.
- cpu_rdata = ram_rdata passes through combinationally at all times.
- FSM states: IDLE, CPU, H_SETUP, H_STROBE, H_HOLD.
  - IDLE: if cpu_act, go to CPU. Else if host_req, latch host_we/addr/wdata and go to H_SETUP.
  - CPU: stay while cpu_act. When it drops, go to IDLE. This gives one mandatory turnaround cycle; a host cycle never starts on the same edge the CPU releases.
  - H_SETUP (1 cycle): latched address driven, cs_b = 0, we_b = oe_b = 1, data_oe = host_we.
  - H_STROBE (STROBE_CYCLES cycles): we_b = 0 for a write, or oe_b = 0 for a read. On the last cycle, host_rdata <= ram_rdata for a read.
  - H_HOLD (1 cycle): strobes high, address and data held, host_ack = 1, retry_cnt cleared, then go to IDLE.
- Preemption:
  - cpu_act in H_SETUP or H_STROBE: abort, go to CPU, retry_cnt += 1 (saturating at RETRY_MAX). The latched op stays pending and restarts from H_SETUP at the next IDLE, without re-sampling host inputs.
  - A partially strobed host write is rewritten in full; this is legal because writes are idempotent.
  - cpu_act in H_HOLD: the strobe has already completed, so host_ack is still issued that cycle and the next state is CPU.
- host_req dropped before ack: the latched op still completes and host_ack is still pulsed. A new request is accepted only when host_req is seen high in IDLE after the ack cycle.
- host_req held high across an ack starts a new op at the next IDLE. The host must drop req on ack if it wants a single op.
- host_starve = (retry_cnt == RETRY_MAX), registered; it clears on ack or reset.
- Address width: the CPU reaches only 0x000..0x0FF; the host reaches the full 0x000..0x7FF.
- Reset mid-operation: the pending op is discarded and no ack is issued.

Decomposition:
- Shared package mc14500_pkg:
  - state enum (IDLE, CPU, H_SETUP, H_STROBE, H_HOLD)
  - RAM_AW = 11, RAM_DW = 8, CPU_AW = 8
- Sub-module ram_arb_strobe_timer: loadable down-counter producing the last-strobe-cycle flag. It is loaded on H_SETUP to H_STROBE and cleared on abort.
- The FSM and output muxing stay in ram_arbiter.

Test Plan:
- Idle host write, addr 0x5A3, data 0xC7, STROBE_CYCLES = 2, no CPU traffic -> we_b low exactly 2 cycles, host_ack 4 cycles after req sampled; a follow-up host read of 0x5A3 returns host_rdata = 0xC7.
- CPU read window, cpu_addr 0x12, RAM[0x012] = 0x3E, host idle -> ram_addr = 0x012 and oe_b = 0 in the same cycle as cpu_rd rises; cpu_rdata = 0x3E.
- Host write to 0x010 preempted by cpu_wr (addr 0x10, data 0x55) in the first strobe cycle -> CPU controls win that cycle, retry_cnt = 1; the host op restarts after the CPU window plus 1 turnaround; the final RAM[0x010] equals the host data and exactly one host_ack is issued.
- cpu_rd asserted during H_HOLD -> host_ack still pulses that cycle; the next state is CPU; no extra host strobe.
- 15 consecutive preemptions with RETRY_MAX = 15 -> host_starve = 1; the next successful ack clears it to 0.
- rst asserted mid-H_STROBE with cpu_wr high -> all strobes are 1 and data_oe = 0 immediately; no ack; after release the state is IDLE and a new request completes normally.

Source files
------------

// File: rtl/mc14500_pkg.sv
// rtl/mc14500_pkg.sv - shared widths and arbiter state encoding for the MC14500 RAM path
package mc14500_pkg;
    localparam int RAM_AW = 11;
    localparam int RAM_DW = 8;
    localparam int CPU_AW = 8;

    typedef enum logic [2:0] {
        IDLE,
        CPU,
        H_SETUP,
        H_STROBE,
        H_HOLD
    } state_t;
endpackage

// File: rtl/ram_arbiter_if.sv
// rtl/ram_arbiter_if.sv - host loader/debug port handshake bundle
interface ram_arbiter_if;
    import mc14500_pkg::*;

    logic              host_req;
    logic              host_we;
    logic [RAM_AW-1:0] host_addr;
    logic [RAM_DW-1:0] host_wdata;
    logic              host_ack;
    logic [RAM_DW-1:0] host_rdata;
    logic              host_starve;

    modport master (
        output host_req, host_we, host_addr, host_wdata,
        input  host_ack, host_rdata, host_starve
    );

    modport slave (
        input  host_req, host_we, host_addr, host_wdata,
        output host_ack, host_rdata, host_starve
    );
endinterface

// File: rtl/ram_arb_strobe_timer.sv
// rtl/ram_arb_strobe_timer.sv - loadable down-counter flagging the last host strobe cycle
module ram_arb_strobe_timer #(
    parameter int STROBE_CYCLES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic clear,
    input  logic dec,
    output logic last
);
    logic [3:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= 4'(STROBE_CYCLES - 1);
        end else if (dec && cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
        end
    end

    assign last = (cnt == 4'd0);
endmodule

// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - 6116 SRAM arbiter: zero-latency CPU override, host cycles in idle gaps
module ram_arbiter
    import mc14500_pkg::*;
#(
    parameter int STROBE_CYCLES = 2,
    parameter int RETRY_MAX     = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [CPU_AW-1:0] cpu_addr,
    input  logic [RAM_DW-1:0] cpu_wdata,
    input  logic              cpu_rd,
    input  logic              cpu_wr,
    output logic [RAM_DW-1:0] cpu_rdata,
    ram_arbiter_if.slave      host,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [RAM_DW-1:0] ram_wdata,
    output logic              ram_data_oe,
    input  logic [RAM_DW-1:0] ram_rdata,
    output logic              ram_cs_b,
    output logic              ram_we_b,
    output logic              ram_oe_b
);
    localparam int RW = $clog2(RETRY_MAX + 1);

    state_t            state, state_next;
    logic              cpu_act, strobe_last, load, abort, accept;
    logic              pending, lat_we;
    logic [RAM_AW-1:0] lat_addr;
    logic [RAM_DW-1:0] lat_wdata;
    logic [RW-1:0]     retry_cnt, retry_next;

    assign cpu_act   = cpu_rd | cpu_wr;
    assign cpu_rdata = ram_rdata;

    ram_arb_strobe_timer #(.STROBE_CYCLES(STROBE_CYCLES)) u_timer (
        .clk   (clk),
        .rst   (rst),
        .load  (load),
        .clear (abort),
        .dec   (state == H_STROBE),
        .last  (strobe_last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= IDLE;
            pending          <= 1'b0;
            lat_we           <= 1'b0;
            lat_addr         <= '0;
            lat_wdata        <= '0;
            retry_cnt        <= '0;
            host.host_starve <= 1'b0;
            host.host_ack    <= 1'b0;
            host.host_rdata  <= '0;
        end else begin
            state            <= state_next;
            retry_cnt        <= retry_next;
            host.host_starve <= (retry_next == RW'(RETRY_MAX));
            host.host_ack    <= (state_next == H_HOLD);
            if (accept) begin
                pending   <= 1'b1;
                lat_we    <= host.host_we;
                lat_addr  <= host.host_addr;
                lat_wdata <= host.host_wdata;
            end else if (state == H_HOLD) begin
                pending <= 1'b0;
            end
            // Capture only on an unpreempted final strobe; otherwise the bus carries CPU data.
            if (state == H_STROBE && strobe_last && !cpu_act && !lat_we) begin
                host.host_rdata <= ram_rdata;
            end
        end
    end

    always_comb begin
        state_next = state;
        load       = 1'b0;
        abort      = 1'b0;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                if (cpu_act) begin
                    state_next = CPU;
                end else if (pending) begin
                    state_next = H_SETUP;
                end else if (host.host_req) begin
                    accept     = 1'b1;
                    state_next = H_SETUP;
                end
            end
            CPU: begin
                if (!cpu_act) state_next = IDLE;
            end
            H_SETUP: begin
                if (cpu_act) begin
                    abort      = 1'b1;
                    state_next = CPU;
                end else begin
                    load       = 1'b1;
                    state_next = H_STROBE;
                end
            end
            H_STROBE: begin
                if (cpu_act) begin
                    abort      = 1'b1;
                    state_next = CPU;
                end else if (strobe_last) begin
                    state_next = H_HOLD;
                end
            end
            H_HOLD:  state_next = cpu_act ? CPU : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        retry_next = retry_cnt;
        if (state == H_HOLD) begin
            retry_next = '0;
        end else if (abort && retry_cnt != RW'(RETRY_MAX)) begin
            retry_next = retry_cnt + RW'(1);
        end
    end

    // CPU override bypasses the state register so it takes effect in the cycle it appears.
    always_comb begin
        ram_cs_b    = 1'b1;
        ram_we_b    = 1'b1;
        ram_oe_b    = 1'b1;
        ram_data_oe = 1'b0;
        ram_addr    = '0;
        ram_wdata   = '0;
        if (!rst) begin
            if (cpu_act) begin
                ram_addr    = {{(RAM_AW - CPU_AW){1'b0}}, cpu_addr};
                ram_wdata   = cpu_wdata;
                ram_cs_b    = 1'b0;
                ram_we_b    = ~cpu_wr;
                ram_oe_b    = ~(cpu_rd & ~cpu_wr);
                ram_data_oe = cpu_wr;
            end else if (state inside {H_SETUP, H_STROBE, H_HOLD}) begin
                ram_addr    = lat_addr;
                ram_wdata   = lat_wdata;
                ram_cs_b    = 1'b0;
                ram_data_oe = lat_we;
                if (state == H_STROBE) begin
                    ram_we_b = ~lat_we;
                    ram_oe_b = lat_we;
                end
            end
        end
    end
endmodule

// File: tb/tb_ram_arbiter.sv
// tb/tb_ram_arbiter.sv - directed and randomized self-checking bench for ram_arbiter
module tb_ram_arbiter;
    import mc14500_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  cpu_addr, cpu_wdata, cpu_rdata;
    logic        cpu_rd, cpu_wr;
    logic [10:0] ram_addr;
    logic [7:0]  ram_wdata, ram_rdata;
    logic        ram_data_oe, ram_cs_b, ram_we_b, ram_oe_b;

    logic [7:0]  ram_mem [0:2047];
    logic [7:0]  exp_mem [0:2047];
    logic [10:0] wq [$];
    int          total = 0;
    int          bad   = 0;

    ram_arbiter_if hif ();

    ram_arbiter #(.STROBE_CYCLES(2), .RETRY_MAX(15)) dut (
        .clk         (clk),
        .rst         (rst),
        .cpu_addr    (cpu_addr),
        .cpu_wdata   (cpu_wdata),
        .cpu_rd      (cpu_rd),
        .cpu_wr      (cpu_wr),
        .cpu_rdata   (cpu_rdata),
        .host        (hif),
        .ram_addr    (ram_addr),
        .ram_wdata   (ram_wdata),
        .ram_data_oe (ram_data_oe),
        .ram_rdata   (ram_rdata),
        .ram_cs_b    (ram_cs_b),
        .ram_we_b    (ram_we_b),
        .ram_oe_b    (ram_oe_b)
    );

    always #5 clk = ~clk;

    // 6116 model: write on the clock while CS and WE are low, read while CS and OE are low
    always @(posedge clk) if (!ram_cs_b && !ram_we_b) ram_mem[ram_addr] <= ram_wdata;
    assign ram_rdata = (!ram_cs_b && !ram_oe_b) ? ram_mem[ram_addr] : 8'h00;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic host_op(input logic we, input logic [10:0] a, input logic [7:0] d,
                           output logic [7:0] rd, output int lat, output int we_cnt);
        int n = 0;
        int w = 0;
        hif.host_req   = 1'b1;
        hif.host_we    = we;
        hif.host_addr  = a;
        hif.host_wdata = d;
        do begin
            @(negedge clk);
            n++;
            if (!ram_we_b) w++;
        end while (!hif.host_ack && n < 40);
        hif.host_req = 1'b0;
        rd     = hif.host_rdata;
        lat    = n;
        we_cnt = w;
        chk("host_ack_seen", hif.host_ack, 1);
        if (hif.host_ack && we) begin
            exp_mem[a] = d;
            wq.push_back(a);
        end
    endtask

    task automatic cpu_write(input logic [7:0] a, input logic [7:0] d, input int len);
        cpu_addr  = a;
        cpu_wdata = d;
        cpu_wr    = 1'b1;
        repeat (len) @(negedge clk);
        cpu_wr = 1'b0;
        exp_mem[{3'b000, a}] = d;
        wq.push_back({3'b000, a});
    endtask

    initial begin
        logic [7:0]  rd, hd, ca, cd;
        logic [10:0] ha;
        int lat, wc, n, acks, ack_at, cnt, sel, dly, len, idx;

        rst = 1'b1; cpu_rd = 1'b1; cpu_wr = 1'b0; cpu_addr = 8'h44; cpu_wdata = 8'h00;
        hif.host_req = 1'b0; hif.host_we = 1'b0; hif.host_addr = '0; hif.host_wdata = '0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_cs_b", ram_cs_b, 1);
        chk("rst_oe_b", ram_oe_b, 1);
        chk("rst_we_b", ram_we_b, 1);
        chk("rst_data_oe", ram_data_oe, 0);
        chk("rst_addr", ram_addr, 0);
        chk("rst_wdata", ram_wdata, 0);
        chk("rst_ack", hif.host_ack, 0);
        chk("rst_rdata", hif.host_rdata, 0);
        chk("rst_starve", hif.host_starve, 0);
        cpu_rd = 1'b0;
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // idle host write then read-back
        host_op(1'b1, 11'h5A3, 8'hC7, rd, lat, wc);
        chk("t1_ack_latency", lat, 4);
        chk("t1_we_width", wc, 2);
        host_op(1'b0, 11'h5A3, 8'h00, rd, lat, wc);
        chk("t1_readback", rd, 8'hC7);

        // CPU read/write windows are zero-latency
        host_op(1'b1, 11'h012, 8'h3E, rd, lat, wc);
        repeat (2) @(negedge clk);
        cpu_rd = 1'b1; cpu_addr = 8'h12; #1;
        chk("t2_addr", ram_addr, 11'h012);
        chk("t2_oe_b", ram_oe_b, 0);
        chk("t2_cs_b", ram_cs_b, 0);
        chk("t2_cpu_rdata", cpu_rdata, 8'h3E);
        @(negedge clk);
        cpu_wr = 1'b1; cpu_wdata = 8'h6B; #1;
        chk("t2_rw_we_b", ram_we_b, 0);
        chk("t2_rw_oe_b", ram_oe_b, 1);
        chk("t2_rw_data_oe", ram_data_oe, 1);
        @(negedge clk);
        cpu_rd = 1'b0; cpu_wr = 1'b0;
        exp_mem[11'h012] = 8'h6B; wq.push_back(11'h012);
        repeat (2) @(negedge clk);

        // host write preempted in its first strobe cycle
        hif.host_req = 1'b1; hif.host_we = 1'b1; hif.host_addr = 11'h010; hif.host_wdata = 8'hA5;
        @(negedge clk);
        chk("t3_setup_cs_b", ram_cs_b, 0);
        chk("t3_setup_we_b", ram_we_b, 1);
        @(negedge clk);
        chk("t3_strobe_we_b", ram_we_b, 0);
        cpu_wr = 1'b1; cpu_addr = 8'h10; cpu_wdata = 8'h55; #1;
        chk("t3_cpu_wdata", ram_wdata, 8'h55);
        chk("t3_cpu_addr", ram_addr, 11'h010);
        chk("t3_cpu_data_oe", ram_data_oe, 1);
        @(negedge clk);
        chk("t3_retry", dut.retry_cnt, 1);
        @(negedge clk);
        cpu_wr = 1'b0;
        acks = 0; ack_at = 0;
        for (int k = 5; k <= 16; k++) begin
            @(negedge clk);
            if (k == 5) chk("t3_turnaround", ram_cs_b, 1);
            if (hif.host_ack) begin
                acks++;
                ack_at = k;
                hif.host_req = 1'b0;
            end
        end
        chk("t3_ack_count", acks, 1);
        chk("t3_ack_time", ack_at, 9);
        chk("t3_final_mem", ram_mem[11'h010], 8'hA5);
        exp_mem[11'h010] = 8'hA5; wq.push_back(11'h010);

        // CPU read arriving in H_HOLD
        hif.host_req = 1'b1; hif.host_we = 1'b0; hif.host_addr = 11'h5A3;
        n = 0;
        do begin @(negedge clk); n++; end while (!hif.host_ack && n < 10);
        chk("t4_ack_latency", n, 4);
        hif.host_req = 1'b0; cpu_rd = 1'b1; cpu_addr = 8'h12; #1;
        chk("t4_ack_in_hold", hif.host_ack, 1);
        chk("t4_rdata", hif.host_rdata, 8'hC7);
        chk("t4_cpu_oe_b", ram_oe_b, 0);
        chk("t4_cpu_addr", ram_addr, 11'h012);
        @(negedge clk);
        chk("t4_state_cpu", dut.state, CPU);
        chk("t4_ack_one_cycle", hif.host_ack, 0);
        @(negedge clk);
        cpu_rd = 1'b0;
        cnt = 0;
        repeat (6) begin
            @(negedge clk);
            if (!ram_cs_b) cnt++;
            if (hif.host_ack) cnt++;
        end
        chk("t4_no_extra_cycle", cnt, 0);

        // repeated preemption drives starvation
        hif.host_req = 1'b1; hif.host_we = 1'b1; hif.host_addr = 11'h321; hif.host_wdata = 8'h9C;
        for (int i = 0; i < 16; i++) begin
            n = 0;
            do begin @(negedge clk); n++; end while (ram_cs_b && n < 10);
            cpu_rd = 1'b1; cpu_addr = 8'h00;
            @(negedge clk);
            cpu_rd = 1'b0;
            if (i == 13) chk("t5_starve_at_14", hif.host_starve, 0);
            if (i == 14) chk("t5_starve_at_15", hif.host_starve, 1);
        end
        chk("t5_retry_saturated", dut.retry_cnt, 15);
        n = 0;
        do begin @(negedge clk); n++; end while (!hif.host_ack && n < 10);
        chk("t5_final_ack", hif.host_ack, 1);
        hif.host_req = 1'b0;
        @(negedge clk);
        chk("t5_starve_cleared", hif.host_starve, 0);
        exp_mem[11'h321] = 8'h9C; wq.push_back(11'h321);
        repeat (2) @(negedge clk);

        // reset in the middle of a strobe with the CPU writing
        hif.host_req = 1'b1; hif.host_we = 1'b1; hif.host_addr = 11'h0AB; hif.host_wdata = 8'h77;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1; cpu_wr = 1'b1; cpu_addr = 8'h20; cpu_wdata = 8'hEE; #1;
        chk("t6_we_b", ram_we_b, 1);
        chk("t6_oe_b", ram_oe_b, 1);
        chk("t6_cs_b", ram_cs_b, 1);
        chk("t6_data_oe", ram_data_oe, 0);
        chk("t6_ack", hif.host_ack, 0);
        hif.host_req = 1'b0;
        @(negedge clk);
        rst = 1'b0; cpu_wr = 1'b0;
        chk("t6_state_idle", dut.state, IDLE);
        cnt = 0;
        repeat (6) begin
            @(negedge clk);
            if (hif.host_ack) cnt++;
        end
        chk("t6_no_ack", cnt, 0);
        host_op(1'b1, 11'h0AB, 8'h77, rd, lat, wc);
        chk("t6_new_op_latency", lat, 4);

        // randomized mix of host ops, CPU windows and contention
        for (int it = 0; it < 30; it++) begin
            sel = $urandom_range(0, 3);
            case (sel)
                0: host_op(1'b1, 11'($urandom_range(0, 2047)), 8'($urandom), rd, lat, wc);
                1: begin
                    idx = $urandom_range(0, wq.size() - 1);
                    ha  = wq[idx];
                    host_op(1'b0, ha, 8'h00, rd, lat, wc);
                    chk("rand_host_read", rd, exp_mem[ha]);
                end
                2: begin
                    ca = 8'($urandom); cd = 8'($urandom);
                    cpu_write(ca, cd, $urandom_range(1, 3));
                    cpu_rd = 1'b1; cpu_addr = ca; #1;
                    chk("rand_cpu_read", cpu_rdata, cd);
                    @(negedge clk);
                    cpu_rd = 1'b0;
                end
                default: begin
                    ha  = 11'($urandom_range(256, 2047));
                    hd  = 8'($urandom);
                    ca  = 8'($urandom);
                    cd  = 8'($urandom);
                    dly = $urandom_range(0, 5);
                    len = $urandom_range(1, 3);
                    fork
                        host_op(1'b1, ha, hd, rd, lat, wc);
                        begin
                            repeat (dly) @(negedge clk);
                            cpu_write(ca, cd, len);
                        end
                    join
                end
            endcase
        end
        repeat (2) @(negedge clk);

        foreach (wq[i]) begin
            ha = wq[i];
            host_op(1'b0, ha, 8'h00, rd, lat, wc);
            chk("sweep_read", rd, exp_mem[ha]);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
